// File: rtl/instr_aligner.sv
// ---------------------------------------------------------------------------
// instr_aligner
//
// Sits between the fetch buffer and the decoder. It takes 32-bit word-aligned
// fetch packets and delivers one complete instruction per cycle, either a
// 16-bit RVC or a 32-bit RVI instruction. A 32-bit instruction may straddle
// two fetch words; its low half is then held in a halfword buffer until the
// next word arrives. Each instruction carries its fetch error code and
// prediction flag. A straddling instruction whose first half ends a predicted
// redirect is reported with an align error.
//
// Build option:
//   ALIGNER_OUT_REG_EN  - when defined, all instruction outputs come from a
//                         register stage (1 cycle latency). When undefined,
//                         outputs are combinational from state and inputs.
//
// Ports:
//   s_clk_i          core clock
//   s_resetn_i       asynchronous active-low reset
//   s_flush_i        redirect: drop held state and the presented word
//   s_flush_half_i   bit 1 of the redirect target (sampled with s_flush_i)
//   s_fetch_valid_i  fetch word valid
//   s_fetch_data_i   fetch word
//   s_fetch_error_i  fetch error code of the word
//   s_fetch_pred_i   taken prediction from the last instruction ending here
//   s_fetch_ready_o  word consumed this cycle
//   s_stall_i        decoder cannot accept an instruction
//   s_instr_valid_o  aligned instruction valid
//   s_instr_o        aligned instruction (bits 31:16 zero for RVC)
//   s_fetch_error_o  fetch error code of the instruction
//   s_align_error_o  instruction is misaligned across a redirect
//   s_prediction_o   prediction flag of the instruction
// ---------------------------------------------------------------------------
module instr_aligner (
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    input  logic        s_flush_i,
    input  logic        s_flush_half_i,
    input  logic        s_fetch_valid_i,
    input  logic [31:0] s_fetch_data_i,
    input  logic [2:0]  s_fetch_error_i,
    input  logic        s_fetch_pred_i,
    output logic        s_fetch_ready_o,
    input  logic        s_stall_i,
    output logic        s_instr_valid_o,
    output logic [31:0] s_instr_o,
    output logic [2:0]  s_fetch_error_o,
    output logic        s_align_error_o,
    output logic        s_prediction_o
);

    // Fetch error encodings shared with the rest of the core (p_hardisc).
    localparam logic [2:0] FETCH_VALID = 3'b000;
    localparam logic [2:0] FETCH_INCER = 3'b001;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_SKIP  = 2'd1,
        ST_HRVC  = 2'd2,
        ST_HSPAN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] h_q, h_d;
    logic [2:0]  eh_q, eh_d;
    logic        ph_q, ph_d;

    // Aligner core results, before stall/flush/reset qualification.
    logic        c_valid;
    logic [31:0] c_instr;
    logic [2:0]  c_err;
    logic        c_aerr;
    logic        c_pred;
    logic        c_take;    // core wants to consume the presented word
    logic        load_h;    // upper half of the presented word goes to H
    logic        adv;       // FSM may advance this cycle

    // ---------------------------------------------------------------------
    // Next-state and core output logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        eh_d    = eh_q;
        ph_d    = ph_q;
        c_valid = 1'b0;
        c_instr = 32'h0;
        c_err   = 3'b000;
        c_aerr  = 1'b0;
        c_pred  = 1'b0;
        c_take  = 1'b0;
        load_h  = 1'b0;

        unique case (state_q)
            ST_EMPTY: begin
                if (s_fetch_valid_i) begin
                    c_valid = 1'b1;
                    c_take  = 1'b1;
                    c_err   = s_fetch_error_i;
                    if (s_fetch_data_i[1:0] == 2'b11) begin
                        c_instr = s_fetch_data_i;
                        c_pred  = s_fetch_pred_i;
                    end else begin
                        // The prediction belongs to the last instruction
                        // ending in the word, i.e. the upper half.
                        c_instr = {16'h0, s_fetch_data_i[15:0]};
                        load_h  = 1'b1;
                    end
                end
            end
            ST_SKIP: begin
                if (s_fetch_valid_i) begin
                    c_take = 1'b1;
                    load_h = 1'b1;
                end
            end
            ST_HRVC: begin
                c_valid = 1'b1;
                c_instr = {16'h0, h_q};
                c_err   = eh_q;
                c_pred  = ph_q;
                state_d = ST_EMPTY;
            end
            ST_HSPAN: begin
                if (ph_q) begin
                    // A redirect was predicted from this halfword, so the
                    // word that follows is not the rest of the instruction.
                    c_valid = 1'b1;
                    c_instr = {16'h0, h_q};
                    c_err   = eh_q;
                    c_aerr  = 1'b1;
                    state_d = ST_EMPTY;
                end else if (s_fetch_valid_i) begin
                    c_valid = 1'b1;
                    c_instr = {s_fetch_data_i[15:0], h_q};
                    // A real fault on the first half outranks whatever the
                    // second word reports.
                    c_err   = ((eh_q != FETCH_VALID) && (eh_q != FETCH_INCER)) ?
                              eh_q : s_fetch_error_i;
                    c_take  = 1'b1;
                    load_h  = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (load_h) begin
            h_d     = s_fetch_data_i[31:16];
            eh_d    = s_fetch_error_i;
            ph_d    = s_fetch_pred_i;
            state_d = (s_fetch_data_i[17:16] != 2'b11) ? ST_HRVC : ST_HSPAN;
        end

        if (s_flush_i) begin
            state_d = s_flush_half_i ? ST_SKIP : ST_EMPTY;
            h_d     = 16'h0;
            eh_d    = 3'b000;
            ph_d    = 1'b0;
        end else if (!adv) begin
            state_d = state_q;
            h_d     = h_q;
            eh_d    = eh_q;
            ph_d    = ph_q;
        end
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            state_q <= ST_EMPTY;
            h_q     <= 16'h0;
            eh_q    <= 3'b000;
            ph_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            eh_q    <= eh_d;
            ph_q    <= ph_d;
        end
    end

    // The word is only taken while out of reset; a flush always drops it.
    assign s_fetch_ready_o = s_resetn_i & (s_flush_i | (c_take & adv));

`ifdef ALIGNER_OUT_REG_EN
    // ---------------------------------------------------------------------
    // Registered output stage
    // ---------------------------------------------------------------------
    logic        out_vld_q;
    logic [31:0] out_instr_q;
    logic [2:0]  out_err_q;
    logic        out_aerr_q;
    logic        out_pred_q;

    // Advance when the register is empty or the decoder drains it.
    assign adv = ~out_vld_q | ~s_stall_i;

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            out_vld_q   <= 1'b0;
            out_instr_q <= 32'h0;
            out_err_q   <= 3'b000;
            out_aerr_q  <= 1'b0;
            out_pred_q  <= 1'b0;
        end else if (s_flush_i) begin
            out_vld_q   <= 1'b0;
        end else if (adv) begin
            out_vld_q   <= c_valid;
            out_instr_q <= c_instr;
            out_err_q   <= c_err;
            out_aerr_q  <= c_aerr;
            out_pred_q  <= c_pred;
        end
    end

    assign s_instr_valid_o = out_vld_q;
    assign s_instr_o       = out_instr_q;
    assign s_fetch_error_o = out_err_q;
    assign s_align_error_o = out_aerr_q;
    assign s_prediction_o  = out_pred_q;
`else
    // ---------------------------------------------------------------------
    // Combinational outputs
    // ---------------------------------------------------------------------
    logic out_en;

    assign adv = ~s_stall_i;

    // While stalled the pending instruction stays presented; only its
    // consumption and the state update are held back.
    assign out_en = s_resetn_i & ~s_flush_i & c_valid;

    assign s_instr_valid_o = out_en;
    assign s_instr_o       = out_en ? c_instr : 32'h0;
    assign s_fetch_error_o = out_en ? c_err   : 3'b000;
    assign s_align_error_o = out_en & c_aerr;
    assign s_prediction_o  = out_en & c_pred;
`endif

endmodule

// File: tb/tb_instr_aligner.sv
module tb_instr_aligner;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush, half, fv, fpred, stall;
    logic [31:0] data;
    logic [2:0]  ferr;
    logic        rdy, vld, aerr, pred;
    logic [31:0] instr;
    logic [2:0]  err;

    always #5 clk = ~clk;

    instr_aligner dut (
        .s_clk_i         (clk),
        .s_resetn_i      (rstn),
        .s_flush_i       (flush),
        .s_flush_half_i  (half),
        .s_fetch_valid_i (fv),
        .s_fetch_data_i  (data),
        .s_fetch_error_i (ferr),
        .s_fetch_pred_i  (fpred),
        .s_fetch_ready_o (rdy),
        .s_stall_i       (stall),
        .s_instr_valid_o (vld),
        .s_instr_o       (instr),
        .s_fetch_error_o (err),
        .s_align_error_o (aerr),
        .s_prediction_o  (pred)
    );

    typedef struct {
        string       name;
        logic        fl, hf, fv, fp, st;
        logic [31:0] d;
        logic [2:0]  fe;
        logic        er, ev, ea, ep;
        logic [31:0] ei;
        logic [2:0]  ee;
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic add(input string n, input logic fl, input logic hf, input logic v,
                       input logic [31:0] d, input logic [2:0] fe, input logic fp,
                       input logic st, input logic er, input logic ev,
                       input logic [31:0] ei, input logic [2:0] ee,
                       input logic ea, input logic ep);
        vec_t x;
        x.name = n; x.fl = fl; x.hf = hf; x.fv = v; x.d = d; x.fe = fe;
        x.fp = fp; x.st = st; x.er = er; x.ev = ev; x.ei = ei; x.ee = ee;
        x.ea = ea; x.ep = ep;
        tbl.push_back(x);
    endtask

    // Data fields are only meaningful when valid is expected, unless full=1.
    task automatic check(input string n, input logic er, input logic ev,
                         input logic [31:0] ei, input logic [2:0] ee,
                         input logic ea, input logic ep, input bit full);
        bit bad;
        nvec++;
        bad = (rdy !== er) || (vld !== ev);
        if (ev || full)
            bad = bad || (instr !== ei) || (err !== ee) || (aerr !== ea) || (pred !== ep);
        if (bad) begin
            nerr++;
            $display("FAIL %s: got rdy=%b vld=%b instr=%h err=%b aerr=%b pred=%b, want rdy=%b vld=%b instr=%h err=%b aerr=%b pred=%b",
                     n, rdy, vld, instr, err, aerr, pred, er, ev, ei, ee, ea, ep);
        end
    endtask

    task automatic drive(input logic fl, input logic hf, input logic v,
                         input logic [31:0] d, input logic [2:0] fe,
                         input logic fp, input logic st);
        flush = fl; half = hf; fv = v; data = d; ferr = fe; fpred = fp; stall = st;
    endtask

    task automatic apply(input vec_t x);
        @(posedge clk);
        #1 drive(x.fl, x.hf, x.fv, x.d, x.fe, x.fp, x.st);
        @(negedge clk);
        check(x.name, x.er, x.ev, x.ei, x.ee, x.ea, x.ep, 1'b0);
    endtask

    initial begin
        //   name            fl hf fv data           ferr    fp st  rdy vld instr          err     ae ep
        add("rvi_aligned",   0, 0, 1, 32'h00A00093, 3'b000, 0, 0,  1, 1, 32'h00A00093, 3'b000, 0, 0);
        add("rvi_err_pred",  0, 0, 1, 32'h00B00113, 3'b010, 1, 0,  1, 1, 32'h00B00113, 3'b010, 0, 1);
        add("idle",          0, 0, 0, 32'h0,        3'b000, 0, 0,  0, 0, 32'h0,        3'b000, 0, 0);
        add("two_rvc_lo",    0, 0, 1, 32'h45054585, 3'b000, 1, 0,  1, 1, 32'h00004585, 3'b000, 0, 0);
        add("two_rvc_hi",    0, 0, 1, 32'h00A00093, 3'b000, 0, 0,  0, 1, 32'h00004505, 3'b000, 0, 1);
        add("after_rvc",     0, 0, 1, 32'h00A00093, 3'b000, 0, 0,  1, 1, 32'h00A00093, 3'b000, 0, 0);
        add("strad_lo",      0, 0, 1, 32'h00934505, 3'b011, 0, 0,  1, 1, 32'h00004505, 3'b011, 0, 0);
        add("strad_hi",      0, 0, 1, 32'h123400A0, 3'b000, 0, 0,  1, 1, 32'h00A00093, 3'b011, 0, 0);
        add("strad_tail",    0, 0, 0, 32'h0,        3'b000, 0, 0,  0, 1, 32'h00001234, 3'b000, 0, 0);
        add("incer_lo",      0, 0, 1, 32'h00934505, 3'b001, 0, 0,  1, 1, 32'h00004505, 3'b001, 0, 0);
        add("incer_hi",      0, 0, 1, 32'hFFFF00A0, 3'b101, 1, 0,  1, 1, 32'h00A00093, 3'b101, 0, 0);
        add("span_break",    0, 0, 1, 32'h00A00093, 3'b000, 0, 0,  0, 1, 32'h0000FFFF, 3'b101, 1, 0);
        add("after_break",   0, 0, 1, 32'h00A00093, 3'b000, 0, 0,  1, 1, 32'h00A00093, 3'b000, 0, 0);
        add("pred_lo",       0, 0, 1, 32'h00934505, 3'b000, 1, 0,  1, 1, 32'h00004505, 3'b000, 0, 0);
        add("pred_break",    0, 0, 1, 32'h00A00093, 3'b000, 0, 0,  0, 1, 32'h00000093, 3'b000, 1, 0);
        add("pred_next",     0, 0, 1, 32'h00A00093, 3'b000, 0, 0,  1, 1, 32'h00A00093, 3'b000, 0, 0);
        add("span_lo",       0, 0, 1, 32'h00934505, 3'b000, 0, 0,  1, 1, 32'h00004505, 3'b000, 0, 0);
        add("span_wait",     0, 0, 0, 32'h0,        3'b000, 0, 0,  0, 0, 32'h0,        3'b000, 0, 0);
        add("span_hi",       0, 0, 1, 32'h000100A0, 3'b000, 0, 0,  1, 1, 32'h00A00093, 3'b000, 0, 0);
        add("span_hrvc",     0, 0, 0, 32'h0,        3'b000, 0, 0,  0, 1, 32'h00000001, 3'b000, 0, 0);
        add("flush_half",    1, 1, 1, 32'h11111111, 3'b000, 0, 0,  1, 0, 32'h0,        3'b000, 0, 0);
        add("skip_lo",       0, 0, 1, 32'h4585ABCD, 3'b000, 0, 0,  1, 0, 32'h0,        3'b000, 0, 0);
        add("skip_hrvc",     0, 0, 0, 32'h0,        3'b000, 0, 0,  0, 1, 32'h00004585, 3'b000, 0, 0);
        add("fl_span_lo",    0, 0, 1, 32'h00934505, 3'b000, 0, 0,  1, 1, 32'h00004505, 3'b000, 0, 0);
        add("flush_full",    1, 0, 1, 32'hDEAD00A0, 3'b000, 0, 0,  1, 0, 32'h0,        3'b000, 0, 0);
        add("post_flush",    0, 0, 1, 32'h00A00093, 3'b000, 0, 0,  1, 1, 32'h00A00093, 3'b000, 0, 0);
        add("flush_nofv",    1, 1, 0, 32'h0,        3'b000, 0, 0,  1, 0, 32'h0,        3'b000, 0, 0);
        add("skip_wait",     0, 0, 0, 32'h0,        3'b000, 0, 0,  0, 0, 32'h0,        3'b000, 0, 0);
        add("skip_span",     0, 0, 1, 32'h00938082, 3'b000, 0, 0,  1, 0, 32'h0,        3'b000, 0, 0);
        add("skip_span_hi",  0, 0, 1, 32'h000000A0, 3'b000, 0, 0,  1, 1, 32'h00A00093, 3'b000, 0, 0);
        add("stall_flush",   1, 0, 0, 32'h0,        3'b000, 0, 1,  1, 0, 32'h0,        3'b000, 0, 0);
        add("empty_stall",   0, 0, 1, 32'h00A00093, 3'b000, 0, 1,  0, 1, 32'h00A00093, 3'b000, 0, 0);
        add("empty_go",      0, 0, 1, 32'h00A00093, 3'b000, 0, 0,  1, 1, 32'h00A00093, 3'b000, 0, 0);
        add("stall_lo",      0, 0, 1, 32'h00934505, 3'b000, 0, 1,  0, 1, 32'h00004505, 3'b000, 0, 0);
        add("stall_lo_go",   0, 0, 1, 32'h00934505, 3'b000, 0, 0,  1, 1, 32'h00004505, 3'b000, 0, 0);
        add("span_stall",    0, 0, 1, 32'h000100A0, 3'b000, 0, 1,  0, 1, 32'h00A00093, 3'b000, 0, 0);
        add("span_go",       0, 0, 1, 32'h000100A0, 3'b000, 0, 0,  1, 1, 32'h00A00093, 3'b000, 0, 0);
        add("span_go_tail",  0, 0, 0, 32'h0,        3'b000, 0, 0,  0, 1, 32'h00000001, 3'b000, 0, 0);

        // Reset state
        rstn = 1'b0;
        drive(0, 0, 0, 32'h0, 3'b000, 0, 0);
        #12;
        check("reset_outs", 0, 0, 32'h0, 3'b000, 0, 0, 1'b1);
        drive(0, 0, 1, 32'h00A00093, 3'b000, 1, 0);
        #1 check("reset_word_held", 0, 0, 32'h0, 3'b000, 0, 0, 1'b1);
        drive(0, 0, 0, 32'h0, 3'b000, 0, 0);
        @(negedge clk);
        rstn = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

        // Stall for three cycles in HRVC, then reset while still stalled.
        @(posedge clk);
        #1 drive(0, 0, 1, 32'h45054585, 3'b000, 0, 0);
        @(negedge clk);
        check("st_rvc_lo", 1, 1, 32'h00004585, 3'b000, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 drive(0, 0, 1, 32'h00A00093, 3'b000, 0, 1);
            @(negedge clk);
            check($sformatf("st_hold%0d", i), 0, 1, 32'h00004505, 3'b000, 0, 0, 1'b0);
        end
        @(posedge clk);
        #1 rstn = 1'b0;
        #1 check("st_rst_mid", 0, 0, 32'h0, 3'b000, 0, 0, 1'b1);
        drive(0, 0, 0, 32'h0, 3'b000, 0, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1 check("st_rst_empty", 0, 0, 32'h0, 3'b000, 0, 0, 1'b1);
        @(posedge clk);
        #1 drive(0, 0, 1, 32'h00A00093, 3'b000, 0, 0);
        @(negedge clk);
        check("st_rst_next", 1, 1, 32'h00A00093, 3'b000, 0, 0, 1'b0);

        @(posedge clk);
        #1 drive(0, 0, 0, 32'h0, 3'b000, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
